// File: rtl/vec_norm_pkg.sv
// Shared definitions for the sequential L2 vector normaliser.
// Holds the controller state encoding and the width-derivation helpers used
// by the top level and the shared divider.
package vec_norm_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SQACC = 3'd1,
    SQRT  = 3'd2,
    DIV   = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Sum-of-squares width: 2*DATAWIDTH plus growth for NUM_CH terms
  // (at least one guard bit, even for a single channel).
  function automatic int f_sumw(input int dw, input int nch);
    int ext;
    ext = $clog2(nch);
    if (ext < 1) ext = 1;
    return 2 * dw + ext;
  endfunction

  function automatic int f_rootw(input int sumw);
    return (sumw + 1) / 2;
  endfunction

  function automatic int f_qw(input int dw, input int frac_bits);
    return dw + frac_bits;
  endfunction

  function automatic int f_outw(input int frac_bits);
    return frac_bits + 1;
  endfunction

  // Width of an index/counter that must hold values 0..n-1 (never zero).
  function automatic int f_idxw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/iter_div_unit.sv
// Restoring unsigned divider, one quotient bit per clock.
// A division takes exactly DW cycles including the start cycle: the first
// quotient bit is produced on the same edge that samples start, so a caller
// can restart the unit every DW cycles with no gap.
//
// Ports:
//   clk, rst      clock, synchronous active-low reset
//   start         begin a division with dividend/divisor (only while !busy)
//   dividend      DW-bit unsigned numerator, sampled on the start cycle
//   divisor       VW-bit unsigned denominator, must stay stable (and nonzero)
//                 for the whole division
//   busy          a division is in progress after its start cycle
//   done          high during the final iteration cycle
//   quotient      low QOUTW bits of the quotient that completes on the edge
//                 ending the done cycle; only meaningful while done is high
module iter_div_unit
  import vec_norm_pkg::*;
#(
  parameter  int DW    = 16,
  parameter  int VW    = 9,
  parameter  int QOUTW = 9,
  localparam int CW    = f_idxw(DW)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DW-1:0]    dividend,
  input  logic [VW-1:0]    divisor,
  output logic             busy,
  output logic             done,
  output logic [QOUTW-1:0] quotient
);

  logic [VW-1:0]    rem_reg;
  logic [QOUTW-1:0] quo_reg;
  logic [DW-1:0]    dvd_reg;
  logic [CW-1:0]    cnt_reg;
  logic             busy_reg;

  logic [VW-1:0]    src_rem;
  logic [QOUTW-1:0] src_quo;
  logic [DW-1:0]    src_dvd;
  logic [VW:0]      trial;
  logic             fits;
  logic [VW-1:0]    rem_next;
  logic [QOUTW-1:0] quo_next;
  logic [DW-1:0]    dvd_next;
  logic             last_step;

  always_comb begin
    // On the start cycle iterate directly on the fresh operands.
    src_rem  = start ? '0 : rem_reg;
    src_quo  = start ? '0 : quo_reg;
    src_dvd  = start ? dividend : dvd_reg;

    trial    = {src_rem, src_dvd[DW-1]};
    fits     = (trial >= {1'b0, divisor});
    // The partial remainder is always below the divisor, so it fits VW bits.
    rem_next = fits ? VW'(trial - {1'b0, divisor}) : VW'(trial);
    // Only the low QOUTW quotient bits are kept; callers guarantee the
    // discarded upper bits are zero.
    quo_next = (src_quo << 1) | QOUTW'(fits);
    dvd_next = src_dvd << 1;

    last_step = start ? (DW == 1) : (cnt_reg == CW'(DW - 1));
  end

  assign busy     = busy_reg;
  assign done     = (start | busy_reg) & last_step;
  assign quotient = quo_next;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rem_reg  <= '0;
      quo_reg  <= '0;
      dvd_reg  <= '0;
      cnt_reg  <= '0;
      busy_reg <= 1'b0;
    end else if (start || busy_reg) begin
      rem_reg  <= rem_next;
      quo_reg  <= quo_next;
      dvd_reg  <= dvd_next;
      cnt_reg  <= start ? CW'(1) : cnt_reg + 1'b1;
      busy_reg <= !last_step;
    end
  end

endmodule

// File: rtl/vec_normalizer_seq.sv
// Time-multiplexed L2 vector normaliser.
// Accepts an NUM_CH-element unsigned vector, accumulates the sum of squares
// one element per cycle, takes a bit-serial integer square root, then divides
// each (element << FRAC_BITS) by that root with one shared serial divider.
// Result latency after the accept cycle: 1 + NUM_CH + ROOTW + NUM_CH*QW
// cycles, or 1 + NUM_CH + ROOTW for an all-zero vector.
//
// Ports:
//   clk, rst   clock, synchronous active-low reset
//   i_valid    input vector valid
//   i_ready    block is idle and will accept a vector
//   in_data    packed vector, element k at [k*DATAWIDTH +: DATAWIDTH]
//   o_valid    result valid, held until o_ready
//   o_ready    downstream accepts the result
//   out_data   normalised elements (OUTW bits each, FRAC_BITS fractional)
//   o_root     floor(sqrt(sum of squares))
//   o_zero     the input vector was all zero
module vec_normalizer_seq
  import vec_norm_pkg::*;
#(
  parameter  int DATAWIDTH   = 8,
  parameter  int FRAC_BITS   = 8,
  parameter  int NUM_CH      = 4,
  parameter  int INSTANCE_ID = 0,
  localparam int SUMW        = f_sumw(DATAWIDTH, NUM_CH),
  localparam int ROOTW       = f_rootw(SUMW),
  localparam int QW          = f_qw(DATAWIDTH, FRAC_BITS),
  localparam int OUTW        = f_outw(FRAC_BITS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_valid,
  output logic                        i_ready,
  input  logic [NUM_CH*DATAWIDTH-1:0] in_data,
  output logic                        o_valid,
  input  logic                        o_ready,
  output logic [NUM_CH*OUTW-1:0]      out_data,
  output logic [ROOTW-1:0]            o_root,
  output logic                        o_zero
);

  localparam int PADW = 2 * ROOTW;          // radicand padded to whole bit pairs
  localparam int KW   = f_idxw(NUM_CH);
  localparam int RCW  = f_idxw(ROOTW);
  localparam logic [KW-1:0]  K_LAST   = KW'(NUM_CH - 1);
  localparam logic [RCW-1:0] BIT_LAST = RCW'(ROOTW - 1);

  generate
    if (NUM_CH < 1 || NUM_CH > 32 || DATAWIDTH < 1 || FRAC_BITS < 1 ||
        INSTANCE_ID < 0) begin : g_bad_param
      $error("vec_normalizer_seq: unsupported parameter set");
    end
  endgenerate

  state_t               state_reg;
  logic [DATAWIDTH-1:0] vec_reg [NUM_CH];
  logic [OUTW-1:0]      out_reg [NUM_CH];
  logic [DATAWIDTH-1:0] in_elem [NUM_CH];
  logic [KW-1:0]        k_reg;
  logic [RCW-1:0]       bit_reg;
  logic [SUMW-1:0]      sum_reg;
  logic [PADW-1:0]      rad_reg;
  logic [ROOTW-1:0]     root_reg;
  logic [ROOTW:0]       rem_reg;
  logic                 i_ready_reg;
  logic                 o_valid_reg;
  logic                 o_zero_reg;
  logic [ROOTW-1:0]     o_root_reg;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign in_elem[gi]                  = in_data[gi*DATAWIDTH +: DATAWIDTH];
      assign out_data[gi*OUTW +: OUTW]    = out_reg[gi];
    end
  endgenerate

  assign i_ready = i_ready_reg;
  assign o_valid = o_valid_reg;
  assign o_zero  = o_zero_reg;
  assign o_root  = o_root_reg;

  // ---------------------------------------------------------------------
  // Sum-of-squares step (shared by SQACC and the DIV dividend select)
  // ---------------------------------------------------------------------
  logic [DATAWIDTH-1:0]   x_sel;
  logic [2*DATAWIDTH-1:0] x_ext;
  logic [2*DATAWIDTH-1:0] sq;
  logic [SUMW-1:0]        sum_next;

  always_comb begin
    x_sel    = vec_reg[k_reg];
    x_ext    = (2*DATAWIDTH)'(x_sel);
    sq       = x_ext * x_ext;
    sum_next = sum_reg + SUMW'(sq);
  end

  // ---------------------------------------------------------------------
  // Restoring square-root step: bring down the next radicand bit pair and
  // try to subtract (4*root + 1).
  // ---------------------------------------------------------------------
  logic [ROOTW+2:0] rem_shift;
  logic [ROOTW+2:0] trial;
  logic             root_up;
  logic [ROOTW:0]   rem_next;
  logic [ROOTW-1:0] root_next;

  always_comb begin
    rem_shift = {rem_reg, rad_reg[PADW-1 -: 2]};
    trial     = {1'b0, root_reg, 2'b01};
    root_up   = (rem_shift >= trial);
    // The remainder never exceeds 2*root, so ROOTW+1 bits hold it.
    rem_next  = (ROOTW+1)'(root_up ? (rem_shift - trial) : rem_shift);
    root_next = (root_reg << 1) | ROOTW'(root_up);
  end

  // ---------------------------------------------------------------------
  // Shared divider: restarted whenever it goes idle inside DIV, so each
  // element costs exactly QW cycles.
  // ---------------------------------------------------------------------
  logic            div_start;
  logic            div_busy;
  logic            div_done;
  logic [QW-1:0]   div_dividend;
  logic [OUTW-1:0] div_quo;

  assign div_start    = (state_reg == DIV) && !div_busy;
  assign div_dividend = {x_sel, {FRAC_BITS{1'b0}}};

  iter_div_unit #(
    .DW    (QW),
    .VW    (ROOTW),
    .QOUTW (OUTW)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (root_reg),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quo)
  );

  // ---------------------------------------------------------------------
  // Controller
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= IDLE;
      k_reg       <= '0;
      bit_reg     <= '0;
      sum_reg     <= '0;
      rad_reg     <= '0;
      root_reg    <= '0;
      rem_reg     <= '0;
      i_ready_reg <= 1'b0;
      o_valid_reg <= 1'b0;
      o_zero_reg  <= 1'b0;
      o_root_reg  <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        vec_reg[k] <= '0;
        out_reg[k] <= '0;
      end
    end else begin
      case (state_reg)
        IDLE: begin
          i_ready_reg <= 1'b1;
          if (i_valid && i_ready_reg) begin
            for (int k = 0; k < NUM_CH; k++) begin
              vec_reg[k] <= in_elem[k];
            end
            sum_reg     <= '0;
            root_reg    <= '0;
            rem_reg     <= '0;
            k_reg       <= '0;
            bit_reg     <= '0;
            i_ready_reg <= 1'b0;
            state_reg   <= SQACC;
          end
        end

        SQACC: begin
          sum_reg <= sum_next;
          if (k_reg == K_LAST) begin
            rad_reg   <= PADW'(sum_next);
            state_reg <= SQRT;
          end else begin
            k_reg <= k_reg + 1'b1;
          end
        end

        SQRT: begin
          root_reg <= root_next;
          rem_reg  <= rem_next;
          rad_reg  <= rad_reg << 2;
          bit_reg  <= bit_reg + 1'b1;
          if (bit_reg == BIT_LAST) begin
            if (sum_reg == '0) begin
              // Nothing to divide by: report the zero vector straight away.
              o_zero_reg  <= 1'b1;
              o_root_reg  <= '0;
              o_valid_reg <= 1'b1;
              for (int k = 0; k < NUM_CH; k++) begin
                out_reg[k] <= '0;
              end
              state_reg <= DONE;
            end else begin
              o_zero_reg <= 1'b0;
              o_root_reg <= root_next;
              k_reg      <= '0;
              state_reg  <= DIV;
            end
          end
        end

        DIV: begin
          if (div_done) begin
            out_reg[k_reg] <= div_quo;
            if (k_reg == K_LAST) begin
              o_valid_reg <= 1'b1;
              state_reg   <= DONE;
            end else begin
              k_reg <= k_reg + 1'b1;
            end
          end
        end

        DONE: begin
          if (o_ready) begin
            o_valid_reg <= 1'b0;
            i_ready_reg <= 1'b1;
            state_reg   <= IDLE;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vec_normalizer_seq.sv
// Scoreboard bench for vec_normalizer_seq at default parameters.
module tb_vec_normalizer_seq;

  localparam int DW    = 8;
  localparam int NCH   = 4;
  localparam int OUTW  = 9;
  localparam int ROOTW = 9;
  localparam int LAT   = 78;
  localparam int LAT0  = 14;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  i_valid;
  logic                  i_ready;
  logic [NCH*DW-1:0]     in_data;
  logic                  o_valid;
  logic                  o_ready;
  logic [NCH*OUTW-1:0]   out_data;
  logic [ROOTW-1:0]      o_root;
  logic                  o_zero;

  always #5 clk = ~clk;

  vec_normalizer_seq #(
    .DATAWIDTH   (8),
    .FRAC_BITS   (8),
    .NUM_CH      (4),
    .INSTANCE_ID (0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_valid  (i_valid),
    .i_ready  (i_ready),
    .in_data  (in_data),
    .o_valid  (o_valid),
    .o_ready  (o_ready),
    .out_data (out_data),
    .o_root   (o_root),
    .o_zero   (o_zero)
  );

  typedef struct {
    logic [NCH*OUTW-1:0] data;
    int                  root;
    bit                  zero;
    int                  lat;
    int                  slot;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [NCH*DW-1:0] pin(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  function automatic logic [NCH*OUTW-1:0] pout(input int a, input int b, input int c, input int d);
    return {9'(d), 9'(c), 9'(b), 9'(a)};
  endfunction

  // ---------------- monitor: pops on every output handshake ----------------
  int rise_slot = 0;
  bit prev_v    = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      prev_v = 1'b0;
    end else begin
      if (o_valid && !prev_v) rise_slot = cyc;
      prev_v = o_valid;
      if (o_valid && o_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          e = sb.pop_front();
          $display("txn root=%0d zero=%0b data=%h latency=%0d", o_root, o_zero, out_data,
                   rise_slot - e.slot);
          check("o_root", 64'(o_root), 64'(e.root));
          check("o_zero", 64'(o_zero), 64'(e.zero));
          check("out_data", 64'(out_data), 64'(e.data));
          check("latency", 64'(rise_slot - e.slot), 64'(e.lat));
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [NCH*DW-1:0] v, input logic [NCH*OUTW-1:0] d,
                      input int root, input bit z, output int slot);
    exp_t e;
    int   n   = 0;
    bit   acc = 1'b0;
    slot = -1;
    @(posedge clk); #1;
    in_data = v;
    i_valid = 1'b1;
    while (!acc) begin
      @(negedge clk);
      if (i_ready) begin
        acc    = 1'b1;
        slot   = cyc;
        e.data = d;
        e.root = root;
        e.zero = z;
        e.lat  = z ? LAT0 : LAT;
        e.slot = cyc;
        sb.push_back(e);
      end else begin
        n++;
        if (n > 400) begin
          check("accept_timeout", 0, 1);
          break;
        end
      end
    end
    @(posedge clk); #1;
    i_valid = 1'b0;
    in_data = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int s0, s1, n;
    rst     = 1'b0;
    i_valid = 1'b0;
    o_ready = 1'b1;
    in_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_o_valid", 64'(o_valid), 0);
    check("reset_out_data", 64'(out_data), 0);
    check("reset_o_root", 64'(o_root), 0);
    check("reset_o_zero", 64'(o_zero), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("ready_after_reset", 64'(i_ready), 1);

    // Directed vectors; consecutive sends are back-to-back.
    send(pin(3, 4, 0, 0),         pout(153, 204, 0, 0),     5,   1'b0, s0);
    send(pin(255, 255, 255, 255), pout(128, 128, 128, 128), 510, 1'b0, s0);
    send(pin(1, 1, 1, 1),         pout(128, 128, 128, 128), 2,   1'b0, s0);
    send(pin(0, 0, 0, 0),         pout(0, 0, 0, 0),         0,   1'b1, s1);
    check("throughput_gap", 64'(s1 - s0), LAT + 1);
    send(pin(1, 2, 2, 0),         pout(85, 170, 170, 0),    3,   1'b0, s0);
    send(pin(10, 0, 0, 1),        pout(256, 0, 0, 25),      10,  1'b0, s0);
    send(pin(0, 0, 0, 200),       pout(0, 0, 0, 256),       200, 1'b0, s0);
    send(pin(255, 0, 0, 0),       pout(256, 0, 0, 0),       255, 1'b0, s0);
    drain();

    // Backpressure: result must hold while o_ready is low; new inputs ignored.
    @(posedge clk); #1;
    o_ready = 1'b0;
    send(pin(3, 4, 0, 0), pout(153, 204, 0, 0), 5, 1'b0, s0);
    n = 0;
    while (!o_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid_seen", 64'(o_valid), 1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      i_valid = i[0];
      in_data = $urandom;
      @(negedge clk);
      check("bp_hold_valid", 64'(o_valid), 1);
      check("bp_hold_data", 64'(out_data), 64'(pout(153, 204, 0, 0)));
      check("bp_hold_root", 64'(o_root), 5);
      check("bp_i_ready", 64'(i_ready), 0);
    end
    @(posedge clk); #1;
    i_valid = 1'b0;
    o_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release_valid", 64'(o_valid), 0);
    check("bp_release_ready", 64'(i_ready), 1);
    check("bp_queue_empty", 64'(sb.size()), 0);

    // Reset in the middle of the divide phase aborts the vector.
    send(pin(3, 4, 0, 0), pout(153, 204, 0, 0), 5, 1'b0, s0);
    while (cyc < s0 + 40) @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    check("midreset_o_valid", 64'(o_valid), 0);
    check("midreset_out_data", 64'(out_data), 0);
    check("midreset_o_root", 64'(o_root), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midreset_ready", 64'(i_ready), 1);
    send(pin(1, 0, 0, 0), pout(256, 0, 0, 0), 1, 1'b0, s0);
    drain();

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #400000;
    mismatched++;
    $display("FAIL watchdog: got still running, required finished by time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vec_normalizer_seq.md
Name: vec_normalizer_seq

Overview:
- Parametrised, time-multiplexed L2 vector normaliser: accepts an NUM_CH-element unsigned vector and returns each element divided by the vector's Euclidean norm, as unsigned fixed point.
- One shared multiply-accumulate, one iterative square-root unit and one iterative divider are sequenced by an FSM, trading latency for area against the fully pipelined normaliser datapath.
- Adds valid/ready on both sides, zero-vector detection and a norm output.
- Sits between the sample front end and downstream fixed-point consumers.

Parameters:
- DATAWIDTH, 8, width of each unsigned input element.
- FRAC_BITS, 8, fractional bits of each normalised output.
- NUM_CH, 4, vector length (>=1, max 32).
- INSTANCE_ID, 0, instance tag for tooling.
- Derived localparams:
  - SUMW = 2*DATAWIDTH + $clog2(NUM_CH) (min 1 extra bit).
  - ROOTW = (SUMW+1)/2.
  - QW = DATAWIDTH + FRAC_BITS.
  - OUTW = FRAC_BITS + 1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low.
- i_valid  in  1  input vector valid.
- i_ready  out  1  block can accept a vector.
- in_data  in  NUM_CH*DATAWIDTH  packed vector; element k at [k*DATAWIDTH +: DATAWIDTH].
- o_valid  out  1  result valid.
- o_ready  in  1  downstream accepts result.
- out_data  out  NUM_CH*OUTW  normalised elements, same packing.
- o_root  out  ROOTW  floor(sqrt(sum of squares)).
- o_zero  out  1  input vector was all zero.

Behaviour:
- Reset: while rst==0 at a clk edge:
  - FSM goes to IDLE.
  - o_valid=0, out_data=0, o_root=0, o_zero=0, all accumulators cleared.
  - i_ready=1 from the first cycle after rst rises.
- Reset mid-operation aborts the current vector with no output.
- FSM states: IDLE, SQACC, SQRT, DIV, DONE.
- IDLE:
  - i_ready=1; all other states drive i_ready=0.
  - On i_valid&&i_ready (cycle 0): capture in_data, clear the sum, go to SQACC.
- SQACC: one element per cycle, sum += x[k]*x[k] in SUMW bits (no overflow possible). After NUM_CH cycles go to SQRT.
- SQRT:
  - Restoring digit-by-digit integer square root, one root bit per cycle, ROOTW cycles.
  - Result is floor(sqrt(sum)); the remainder is discarded.
  - Then: if sum==0, go to DONE with o_zero=1, out_data=0, o_root=0; otherwise go to DIV.
- DIV:
  - Per element k = 0..NUM_CH-1, restoring division of (x[k] << FRAC_BITS), QW bits, by the root, one quotient bit per cycle, QW cycles per element.
  - Quotient is floor; the low OUTW bits are stored to out_data[k].
  - Since x[k] <= root, the quotient is <= 2^FRAC_BITS, so no saturation is needed.
- Output timing and hold:
  - o_valid rises in the first DONE cycle, at cycle L = 1 + NUM_CH + ROOTW + NUM_CH*QW after the accept (78 for defaults).
  - For a zero vector, L0 = 1 + NUM_CH + ROOTW (14 for defaults).
- DONE:
  - o_valid=1; out_data, o_root and o_zero are held stable until o_valid&&o_ready.
  - On that handshake, the next cycle is IDLE with o_valid=0; outputs keep their last values.
- No new vector is accepted while a vector is in flight. Peak throughput is one vector per L+1 cycles.
- i_valid while not ready is ignored. in_data may change freely after the accept.
- NUM_CH=1: any nonzero x gives out_data = 2^FRAC_BITS.

Decomposition:
- Package vec_norm_pkg:
  - state enum typedef (IDLE..DONE).
  - functions for SUMW/ROOTW/QW/OUTW derivation.
- Natural sub-module: iter_div_unit.
  - Start/done handshake, QW-cycle restoring divider.
  - Instantiated once and reused per element.
- The square root stays inline in the top FSM.

Test Plan:
- Defaults, in_data={3,4,0,0} (k=0..3) -> after 78 cycles o_valid=1, o_root=5, out_data={153,204,0,0}, o_zero=0.
- in_data={255,255,255,255} -> o_root=510, out_data={128,128,128,128}. Then {1,1,1,1} -> o_root=2, all 128.
- in_data={0,0,0,0} -> o_valid at cycle 14, o_zero=1, o_root=0, out_data all 0.
- Backpressure:
  - Vector {3,4,0,0} with o_ready held 0 for 20 cycles after o_valid -> outputs stable, i_ready=0, extra i_valid pulses ignored.
  - Then o_ready=1 -> o_valid=0 next cycle, i_ready=1.
- Reset mid-DIV: rst=0 at cycle 40 -> next cycle o_valid=0, out_data=0, i_ready=1 after release. A fresh vector {1,0,0,0} then yields out_data={256,0,0,0}, o_root=1.
- NUM_CH=8, DATAWIDTH=12 build: random vectors vs golden floor model, plus back-to-back i_valid held high -> exactly one accept per L+1 cycles.
